// File: rtl/iob_ptfloat_unpack.sv
// Pipelined pt-float unpacker: splits {ew, exp, man} into an exponent width, a
// sign-extended exponent and a left-aligned two's-complement mantissa.
module iob_ptfloat_unpack #(
   parameter  int DATA_W    = 32,
   parameter  int EW_W      = 4,
   localparam int EXP_MAX_W = 2**EW_W - 1,
   localparam int MAN_MAX_W = DATA_W - EW_W
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [DATA_W-1:0]      data_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [EW_W-1:0]        ew_o,
   output logic [EXP_MAX_W+1:0]   exp_o,
   output logic [MAN_MAX_W-1:0]   man_o,
   output logic                   zero_o,
   output logic                   nar_o
);

   localparam int SH_W = $clog2(MAN_MAX_W + 1);

   logic                  s1_valid_q, s1_valid_d;
   logic [EW_W-1:0]       s1_ew_q,    s1_ew_d;
   logic [MAN_MAX_W-1:0]  s1_body_q,  s1_body_d;
   logic                  s1_nar_q,   s1_nar_d;

   logic                  s2_valid_q, s2_valid_d;
   logic [EW_W-1:0]       ew_q,       ew_d;
   logic [EXP_MAX_W+1:0]  exp_q,      exp_d;
   logic [MAN_MAX_W-1:0]  man_q,      man_d;
   logic                  zero_q,     zero_d;
   logic                  nar_q,      nar_d;

   logic                  s1_adv, s2_adv;
   logic [SH_W-1:0]       shamt;
   logic [MAN_MAX_W-1:0]  rsh;
   logic                  exp_sign;
   logic [EXP_MAX_W+1:0]  exp_raw;
   logic [MAN_MAX_W-1:0]  man_raw;

   always_comb begin
      s2_adv = ~s2_valid_q | out_ready_i;
      s1_adv = ~s1_valid_q | s2_adv;
   end

   // Stage 1: capture the raw fields; data registers only load on a real transfer.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_ew_d    = s1_ew_q;
      s1_body_d  = s1_body_q;
      s1_nar_d   = s1_nar_q;
      if (s1_adv) begin
         s1_valid_d = in_valid_i;
         if (in_valid_i) begin
            s1_ew_d   = data_i[DATA_W-1 -: EW_W];
            s1_body_d = data_i[MAN_MAX_W-1:0];
            s1_nar_d  = (data_i == {1'b1, {(DATA_W-1){1'b0}}});
         end
      end
   end

   // The exponent field sits in the top ew bits of the body; right-align it,
   // then extend from bit ew-1 (ew==0 yields an all-zero exponent).
   always_comb begin
      shamt    = SH_W'(MAN_MAX_W) - SH_W'(s1_ew_q);
      rsh      = s1_body_q >> shamt;
      exp_sign = 1'b0;
      for (int unsigned i = 0; i < EXP_MAX_W; i++) begin
         if (32'(s1_ew_q) == i + 1) exp_sign = rsh[i];
      end
      exp_raw = '0;
      for (int unsigned i = 0; i < EXP_MAX_W + 2; i++) begin
         exp_raw[i] = (i < 32'(s1_ew_q)) ? rsh[i] : exp_sign;
      end
      man_raw = s1_body_q << s1_ew_q;
   end

   // Stage 2: register the unpacked fields, forcing the NaR encoding.
   always_comb begin
      s2_valid_d = s2_valid_q;
      ew_d       = ew_q;
      exp_d      = exp_q;
      man_d      = man_q;
      zero_d     = zero_q;
      nar_d      = nar_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            ew_d   = s1_ew_q;
            exp_d  = s1_nar_q ? '0 : exp_raw;
            man_d  = s1_nar_q ? '0 : man_raw;
            zero_d = ~s1_nar_q & (man_raw == '0);
            nar_d  = s1_nar_q;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_ew_q    <= '0;
         s1_body_q  <= '0;
         s1_nar_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         ew_q       <= '0;
         exp_q      <= '0;
         man_q      <= '0;
         zero_q     <= 1'b0;
         nar_q      <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_ew_q    <= s1_ew_d;
         s1_body_q  <= s1_body_d;
         s1_nar_q   <= s1_nar_d;
         s2_valid_q <= s2_valid_d;
         ew_q       <= ew_d;
         exp_q      <= exp_d;
         man_q      <= man_d;
         zero_q     <= zero_d;
         nar_q      <= nar_d;
      end
   end

   assign in_ready_o  = s1_adv;
   assign out_valid_o = s2_valid_q;
   assign ew_o        = ew_q;
   assign exp_o       = exp_q;
   assign man_o       = man_q;
   assign zero_o      = zero_q;
   assign nar_o       = nar_q;

endmodule

// File: tb/tb_iob_ptfloat_unpack.sv
// Directed and randomized checks of the pt-float unpacker (DATA_W=32, EW_W=4).
module tb_iob_ptfloat_unpack;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, zero, nar;
   logic [31:0] data;
   logic [3:0]  ew;
   logic [16:0] expo;
   logic [27:0] man;
   logic [50:0] got;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   assign got = {ew, expo, man, zero, nar};

   iob_ptfloat_unpack #(.DATA_W(32), .EW_W(4)) dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .data_i(data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .ew_o(ew), .exp_o(expo), .man_o(man), .zero_o(zero), .nar_o(nar)
   );

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d passes=%0d", checks, passes);
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Presents one word with the consumer ready; returns out_valid after the capture edge.
   task automatic run_word(input logic [31:0] d, output logic early_valid);
      in_valid  = 1'b1;
      data      = d;
      out_ready = 1'b1;
      tick();
      in_valid    = 1'b0;
      early_valid = out_valid;
      tick();
   endtask

   function automatic logic [50:0] ref_unpack(input logic [31:0] d);
      int unsigned e;
      longint      f, lim;
      logic [63:0] wide;
      logic [16:0] x;
      logic [27:0] m;
      logic        n, z;
      e    = d[31:28];
      n    = (d == 32'h8000_0000);
      wide = 64'(d[27:0]) << e;
      m    = wide[27:0];
      f    = 0;
      if (e != 0) begin
         f   = longint'(d[27:0] >> (28 - e));
         lim = longint'(1) << (e - 1);
         if (f >= lim) f = f - (longint'(1) << e);
      end
      x = 17'(f);
      z = !n && (m == 28'd0);
      if (n) begin
         x = '0;
         m = '0;
      end
      return {4'(e), x, m, z, n};
   endfunction

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b1; data = 32'h3A40_0000; out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
      else passes++;
      checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
      else passes++;
      checks++;
      if (got !== 51'd0) $display("FAIL reset_outputs: got %h want 0", got);
      else passes++;
      tick();
      checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_ignored_input: out_valid got %b want 0", out_valid);
      else passes++;
   endtask

   task automatic test_single_words;
      logic [31:0] words [6];
      logic [50:0] exps  [6];
      logic        early;
      words[0] = 32'h3A40_0000; exps[0] = {4'h3, 17'h1FFFD, 28'h200_0000, 1'b0, 1'b0};
      words[1] = 32'h0400_0000; exps[1] = {4'h0, 17'h00000, 28'h400_0000, 1'b0, 1'b0};
      words[2] = 32'h0000_0000; exps[2] = {4'h0, 17'h00000, 28'h000_0000, 1'b1, 1'b0};
      words[3] = 32'h1000_0000; exps[3] = {4'h1, 17'h00000, 28'h000_0000, 1'b1, 1'b0};
      words[4] = 32'h8000_0001; exps[4] = {4'h8, 17'h00000, 28'h000_0100, 1'b0, 1'b0};
      words[5] = 32'h1800_0000; exps[5] = {4'h1, 17'h1FFFF, 28'h000_0000, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         run_word(words[i], early);
         checks++;
         if (early !== 1'b0) $display("FAIL single_latency[%0d]: early out_valid %b want 0", i, early);
         else passes++;
         checks++;
         if (out_valid !== 1'b1) $display("FAIL single_valid[%0d]: got %b want 1", i, out_valid);
         else passes++;
         checks++;
         if (got !== exps[i]) $display("FAIL single_fields[%0d]: got %h want %h", i, got, exps[i]);
         else passes++;
      end
      tick();
   endtask

   task automatic test_nar_ew15;
      logic early;
      run_word(32'h8000_0000, early);
      checks++;
      if (got !== {4'h8, 17'h0, 28'h0, 1'b0, 1'b1})
         $display("FAIL nar_fields: got %h want %h", got, {4'h8, 17'h0, 28'h0, 1'b0, 1'b1});
      else passes++;
      run_word(32'hF7FF_0001, early);
      checks++;
      if (got !== {4'hF, 17'h03FF8, 28'h000_8000, 1'b0, 1'b0})
         $display("FAIL ew15_fields: got %h want %h", got, {4'hF, 17'h03FF8, 28'h000_8000, 1'b0, 1'b0});
      else passes++;
      checks++;
      if (expo[16:14] !== 3'b000) $display("FAIL ew15_sign: got %b want 000", expo[16:14]);
      else passes++;
      tick();
   endtask

   task automatic test_back_to_back;
      int          sent = 0;
      int          rx = 0;
      logic        stall_prev = 1'b0;
      logic [50:0] held = '0;
      for (int c = 0; c < 40 && rx < 8; c++) begin
         in_valid  = (sent < 8);
         data      = 32'(sent + 1);
         out_ready = !(c >= 3 && c <= 6);
         #1;
         if (c >= 3 && c <= 6) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1)
               $display("FAIL b2b_stall[%0d]: in_ready %b out_valid %b want 0 1", c, in_ready, out_valid);
            else passes++;
         end
         if (stall_prev) begin
            checks++;
            if (got !== held) $display("FAIL b2b_hold[%0d]: got %h want %h", c, got, held);
            else passes++;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (got !== {4'h0, 17'h0, 28'(rx + 1), 1'b0, 1'b0})
               $display("FAIL b2b_order[%0d]: got %h want man %0d", rx, got, rx + 1);
            else passes++;
            rx++;
         end
         stall_prev = out_valid && !out_ready;
         held       = got;
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (rx !== 8 || sent !== 8) $display("FAIL b2b_count: received %0d sent %0d want 8 8", rx, sent);
      else passes++;
      tick();
      checks++;
      if (out_valid !== 1'b0) $display("FAIL b2b_no_dup: out_valid %b want 0", out_valid);
      else passes++;
   endtask

   task automatic test_mid_reset;
      logic early;
      out_ready = 1'b0; in_valid = 1'b1; data = 32'h3A40_0000;
      tick();
      data = 32'h0400_0000;
      tick();
      #1;
      checks++;
      if (in_ready !== 1'b0) $display("FAIL mreset_full: in_ready %b want 0", in_ready);
      else passes++;
      rst = 1'b1; in_valid = 1'b1; data = 32'hF7FF_0001; out_ready = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL mreset_flags: out_valid %b in_ready %b want 0 1", out_valid, in_ready);
      else passes++;
      checks++;
      if (got !== 51'd0) $display("FAIL mreset_outputs: got %h want 0", got);
      else passes++;
      run_word(32'h3A40_0000, early);
      checks++;
      if (early !== 1'b0 || out_valid !== 1'b1)
         $display("FAIL mreset_latency: early %b valid %b want 0 1", early, out_valid);
      else passes++;
      checks++;
      if (got !== {4'h3, 17'h1FFFD, 28'h200_0000, 1'b0, 1'b0})
         $display("FAIL mreset_word: got %h want %h", got, {4'h3, 17'h1FFFD, 28'h200_0000, 1'b0, 1'b0});
      else passes++;
      tick();
      checks++;
      if (out_valid !== 1'b0) $display("FAIL mreset_drop: out_valid %b want 0", out_valid);
      else passes++;
   endtask

   task automatic test_random;
      logic [50:0] q [$];
      logic [50:0] want;
      int          n_words = 3000;
      int          sent = 0;
      int          rx = 0;
      int unsigned r;
      for (int c = 0; c < 30000 && rx < n_words; c++) begin
         in_valid = (sent < n_words) && ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 15);
         if (r == 0)      data = 32'h8000_0000;
         else if (r == 1) data = {4'($urandom_range(0, 15)), 28'd0};
         else             data = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               $display("FAIL rand_spurious[%0d]: output %h with nothing pending", rx, got);
            end else begin
               want = q.pop_front();
               if (got !== want) $display("FAIL rand_word[%0d]: got %h want %h", rx, got, want);
               else passes++;
            end
            rx++;
         end
         if (in_valid && in_ready) begin
            q.push_back(ref_unpack(data));
            sent++;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      checks++;
      if (rx !== n_words || q.size() !== 0)
         $display("FAIL rand_count: received %0d pending %0d want %0d 0", rx, q.size(), n_words);
      else passes++;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data = '0;
      test_reset();
      test_single_words();
      test_nar_ew15();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
